// File: rtl/vga_text_console_writer.sv
// vga_text_console_writer: byte stream to VGA text VRAM over Avalon-MM.
// Define VGA_CONSOLE_INVERSE_EN for the 0x0E/0x0F inverse-video attribute.
module vga_text_console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CHAR_VALID,
  input  logic [7:0]  CHAR_DATA,
  output logic        CHAR_READY,
  output logic        AVM_CS,
  output logic        AVM_WRITE,
  output logic [9:0]  AVM_ADDR,
  output logic [3:0]  AVM_BYTE_EN,
  output logic [31:0] AVM_WRITEDATA,
  input  logic        AVM_WAITREQUEST,
  output logic [6:0]  CURSOR_COL,
  output logic [4:0]  CURSOR_ROW,
  output logic        BUSY
);

  localparam logic [9:0] WPR     = 10'(COLS / 4);
  localparam logic [9:0] LAST    = 10'(ROWS * COLS / 4 - 1);
  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        write_q, write_d;
  logic [9:0]  addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] data_q, data_d;

  logic        accept;
  logic        done;
  logic        is_cr, is_lf, is_bs, is_ff;
  logic        iv;
  logic [4:0]  row_inc;
  logic [9:0]  glyph_addr;
  logic [7:0]  glyph;

`ifdef VGA_CONSOLE_INVERSE_EN
  logic inv_q, inv_d;
  logic is_so, is_si;
  assign is_so = (CHAR_DATA == 8'h0E);
  assign is_si = (CHAR_DATA == 8'h0F);
  assign iv    = inv_q;
`else
  assign iv    = 1'b0;
`endif

  assign accept     = CHAR_VALID & ready_q;
  assign done       = write_q & ~AVM_WAITREQUEST;
  assign is_cr      = (CHAR_DATA == 8'h0D);
  assign is_lf      = (CHAR_DATA == 8'h0A);
  assign is_bs      = (CHAR_DATA == 8'h08);
  assign is_ff      = (CHAR_DATA == 8'h0C);
  assign row_inc    = (row_q == ROW_MAX) ? 5'd0 : row_q + 5'd1;
  assign glyph_addr = {5'd0, row_q} * WPR + {5'd0, col_q[6:2]};
  assign glyph      = {iv, CHAR_DATA[6:0]};

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    write_d = write_q;
    addr_d  = addr_q;
    be_d    = be_q;
    data_d  = data_q;
`ifdef VGA_CONSOLE_INVERSE_EN
    inv_d   = inv_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_cr: col_d = 7'd0;
            is_lf: row_d = row_inc;
            is_bs: begin
              if (col_q != 7'd0) col_d = col_q - 7'd1;
            end
            is_ff: begin
              state_d = CLEAR;
              ready_d = 1'b0;
              busy_d  = 1'b1;
              write_d = 1'b1;
              addr_d  = 10'd0;
              be_d    = 4'b1111;
              data_d  = 32'd0;
            end
`ifdef VGA_CONSOLE_INVERSE_EN
            is_so: inv_d = 1'b1;
            is_si: inv_d = 1'b0;
`endif
            default: begin
              state_d = WRITE;
              ready_d = 1'b0;
              busy_d  = 1'b1;
              write_d = 1'b1;
              addr_d  = glyph_addr;
              be_d    = 4'b0001 << col_q[1:0];
              data_d  = {4{glyph}};
            end
          endcase
        end
      end
      WRITE: begin
        if (done) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          write_d = 1'b0;
          if (col_q == COL_MAX) begin
            col_d = 7'd0;
            row_d = row_inc;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      end
      CLEAR: begin
        if (done) begin
          if (addr_q == LAST) begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            write_d = 1'b0;
            col_d   = 7'd0;
            row_d   = 5'd0;
          end else begin
            addr_d = addr_q + 10'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      col_q   <= 7'd0;
      row_q   <= 5'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 10'd0;
      be_q    <= 4'd0;
      data_q  <= 32'd0;
`ifdef VGA_CONSOLE_INVERSE_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      data_q  <= data_d;
`ifdef VGA_CONSOLE_INVERSE_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign CHAR_READY    = ready_q;
  assign AVM_CS        = write_q;
  assign AVM_WRITE     = write_q;
  assign AVM_ADDR      = addr_q;
  assign AVM_BYTE_EN   = be_q;
  assign AVM_WRITEDATA = data_q;
  assign CURSOR_COL    = col_q;
  assign CURSOR_ROW    = row_q;
  assign BUSY          = busy_q;

endmodule

// File: tb/tb_vga_text_console_writer.sv
// Bench for vga_text_console_writer: vector table, bus scoreboard,
// hand-written clear/reset and back-to-back control-code sequences.
`timescale 1ns/1ps
module tb_vga_text_console_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CHAR_VALID = 1'b0;
  logic [7:0]  CHAR_DATA = 8'h00;
  logic        CHAR_READY;
  logic        AVM_CS;
  logic        AVM_WRITE;
  logic [9:0]  AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic        AVM_WAITREQUEST = 1'b0;
  logic [6:0]  CURSOR_COL;
  logic [4:0]  CURSOR_ROW;
  logic        BUSY;

  vga_text_console_writer #(.COLS(80), .ROWS(30)) dut (
    .CLK(clk),
    .RESET(rst_n),
    .CHAR_VALID(CHAR_VALID),
    .CHAR_DATA(CHAR_DATA),
    .CHAR_READY(CHAR_READY),
    .AVM_CS(AVM_CS),
    .AVM_WRITE(AVM_WRITE),
    .AVM_ADDR(AVM_ADDR),
    .AVM_BYTE_EN(AVM_BYTE_EN),
    .AVM_WRITEDATA(AVM_WRITEDATA),
    .AVM_WAITREQUEST(AVM_WAITREQUEST),
    .CURSOR_COL(CURSOR_COL),
    .CURSOR_ROW(CURSOR_ROW),
    .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } bus_t;

  typedef struct {
    logic [7:0] code;
    int         nwait;
    int         col;
    int         row;
  } vec_t;

  bus_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   run_len = 0;
  int   last_run = 0;
  int   hold_at[600];
  int   wait_left = 0;
  logic [9:0] wait_addr = 10'd0;
  logic prev_hold = 1'b0;
  bus_t prev_bus;
  int   mcol = 0;
  int   mrow = 0;
  logic inv_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave stall generator: stalls a chosen address for a chosen count.
  always @(negedge clk) begin
    if (AVM_WRITE && AVM_ADDR == wait_addr && wait_left > 0) begin
      AVM_WAITREQUEST = 1'b1;
      wait_left--;
    end else begin
      AVM_WAITREQUEST = 1'b0;
    end
  end

  // Bus monitor: a write completes at the next rising edge.
  always @(negedge clk) begin
    bus_t cur;
    bus_t e;
    #2;
    cur = '{AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA};
    if (!rst_n) begin
      prev_hold = 1'b0;
      run_len = 0;
    end else begin
      chk("cs_eq_write", AVM_CS, AVM_WRITE);
      if (prev_hold) begin
        chk("hold_write", AVM_WRITE, 1'b1);
        chk("hold_fields", (cur == prev_bus), 1'b1);
      end
      if (AVM_WRITE) begin
        run_len++;
        if (!AVM_WAITREQUEST) begin
          if (AVM_ADDR < 10'd600) hold_at[AVM_ADDR] = run_len;
          last_run = run_len;
          run_len = 0;
          done_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0h data %0h",
                     AVM_ADDR, AVM_WRITEDATA);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", AVM_ADDR, e.addr);
            chk("wr_be", AVM_BYTE_EN, e.be);
            chk("wr_data", AVM_WRITEDATA, e.data);
          end
        end
      end else begin
        run_len = 0;
      end
      prev_hold = AVM_WRITE & AVM_WAITREQUEST;
      prev_bus = cur;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  function automatic logic is_glyph(input logic [7:0] c);
    logic g;
    g = !(c == 8'h0D || c == 8'h0A || c == 8'h08 || c == 8'h0C);
`ifdef VGA_CONSOLE_INVERSE_EN
    if (c == 8'h0E || c == 8'h0F) g = 1'b0;
`endif
    return g;
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(CHAR_READY && !BUSY) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", CHAR_READY & ~BUSY, 1'b1);
  endtask

  task automatic send(input logic [7:0] code, input int nwait,
                      input logic [9:0] waddr);
    int t;
    t = 0;
    while (!CHAR_READY && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", CHAR_READY, 1'b1);
    wait_addr = waddr;
    wait_left = nwait;
    CHAR_VALID = 1'b1;
    CHAR_DATA = code;
    @(negedge clk);
    CHAR_VALID = 1'b0;
  endtask

  task automatic step(input logic [7:0] code, input int nwait);
    logic g;
    bus_t e;
    g = is_glyph(code);
    e.addr = 10'(mrow * 20 + mcol / 4);
    e.be = 4'(1 << (mcol % 4));
    e.data = {4{inv_m, code[6:0]}};
    if (g) exp_q.push_back(e);
    send(code, nwait, e.addr);
    chk("write_after_accept", AVM_WRITE, g);
    if (code == 8'h0D) mcol = 0;
    else if (code == 8'h0A) mrow = (mrow + 1) % 30;
    else if (code == 8'h08) begin
      if (mcol > 0) mcol--;
    end
`ifdef VGA_CONSOLE_INVERSE_EN
    else if (code == 8'h0E) inv_m = 1'b1;
    else if (code == 8'h0F) inv_m = 1'b0;
`endif
    else if (mcol == 79) begin
      mcol = 0;
      mrow = (mrow + 1) % 30;
    end else mcol++;
    wait_idle();
    chk("cursor_col", CURSOR_COL, mcol);
    chk("cursor_row", CURSOR_ROW, mrow);
    if (g) begin
      chk("hold_len", last_run, nwait + 1);
      chk("queue_drained", exp_q.size(), 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_write", AVM_WRITE, 1'b0);
    chk("rst_cs", AVM_CS, 1'b0);
    chk("rst_addr", AVM_ADDR, 0);
    chk("rst_be", AVM_BYTE_EN, 0);
    chk("rst_data", AVM_WRITEDATA, 0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_col", CURSOR_COL, 0);
    chk("rst_row", CURSOR_ROW, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mcol = 0;
    mrow = 0;
    inv_m = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_ready", CHAR_READY, 1'b1);
  endtask

  task automatic push_clear();
    bus_t e;
    for (int i = 0; i < 600; i++) begin
      e = '{10'(i), 4'b1111, 32'd0};
      exp_q.push_back(e);
    end
  endtask

  vec_t vecs[16];

  initial begin
    int n;
    int base;
    int t;
    vecs[0]  = '{8'h41, 0, 1, 0};
    vecs[1]  = '{8'h0D, 0, 0, 0};
    vecs[2]  = '{8'h0A, 0, 0, 1};
    vecs[3]  = '{8'h0A, 0, 0, 2};
    vecs[4]  = '{8'h08, 0, 0, 2};
    vecs[5]  = '{8'h61, 0, 1, 2};
    vecs[6]  = '{8'h62, 0, 2, 2};
    vecs[7]  = '{8'h63, 0, 3, 2};
    vecs[8]  = '{8'h64, 0, 4, 2};
    vecs[9]  = '{8'h65, 0, 5, 2};
    vecs[10] = '{8'h5A, 3, 6, 2};
    vecs[11] = '{8'h08, 0, 5, 2};
    vecs[12] = '{8'h58, 1, 6, 2};
    vecs[13] = '{8'h0D, 0, 0, 2};
    vecs[14] = '{8'hC1, 0, 1, 2};
    vecs[15] = '{8'h7F, 0, 2, 2};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].code, vecs[i].nwait);
      chk("vec_col", CURSOR_COL, vecs[i].col);
      chk("vec_row", CURSOR_ROW, vecs[i].row);
    end

    // Cursor to (10,3), then CR/LF/BS on consecutive cycles.
    do_reset();
    for (int i = 0; i < 3; i++) step(8'h0A, 0);
    for (int i = 0; i < 10; i++) step(8'(8'h30 + i), 0);
    base = done_cnt;
    CHAR_VALID = 1'b1;
    CHAR_DATA = 8'h0D;
    chk("b2b_ready_cr", CHAR_READY, 1'b1);
    @(negedge clk);
    chk("b2b_col_cr", CURSOR_COL, 0);
    chk("b2b_ready_lf", CHAR_READY, 1'b1);
    CHAR_DATA = 8'h0A;
    @(negedge clk);
    chk("b2b_row_lf", CURSOR_ROW, 4);
    chk("b2b_ready_bs", CHAR_READY, 1'b1);
    CHAR_DATA = 8'h08;
    @(negedge clk);
    CHAR_VALID = 1'b0;
    chk("b2b_col", CURSOR_COL, 0);
    chk("b2b_row", CURSOR_ROW, 4);
    chk("b2b_no_write", AVM_WRITE, 1'b0);
    repeat (3) @(negedge clk);
    chk("b2b_write_cnt", done_cnt - base, 0);
    mcol = 0;
    mrow = 4;

    // Cursor to (79,29) and write the last cell.
    do_reset();
    for (int i = 0; i < 29; i++) step(8'h0A, 0);
    for (int i = 0; i < 79; i++) step(8'(8'h40 + (i % 26)), 0);
    chk("pre_last_col", CURSOR_COL, 79);
    exp_q.push_back('{10'h257, 4'b1000, 32'h21212121});
    send(8'h21, 0, 10'h257);
    wait_idle();
    chk("wrap_col", CURSOR_COL, 0);
    chk("wrap_row", CURSOR_ROW, 0);
    chk("wrap_queue", exp_q.size(), 0);
    mcol = 0;
    mrow = 0;

    // Zero-wait clear: BUSY exactly 600 cycles.
    step(8'h78, 0);
    push_clear();
    send(8'h0C, 0, 10'd0);
    n = 0;
    while (BUSY && n < 700) begin
      n++;
      @(negedge clk);
    end
    chk("clear_busy_cycles", n, 600);
    chk("clear_col", CURSOR_COL, 0);
    chk("clear_row", CURSOR_ROW, 0);
    chk("clear_queue", exp_q.size(), 0);
    mcol = 0;
    mrow = 0;

    // Clear stalled on word 300, then reset while word 450 is on the bus.
    step(8'h79, 0);
    push_clear();
    base = done_cnt;
    send(8'h0C, 2, 10'd300);
    t = 0;
    while (!(AVM_WRITE && AVM_ADDR == 10'd450) && t < 800) begin
      @(negedge clk);
      t++;
    end
    chk("reach_word_450", AVM_ADDR, 10'd450);
    rst_n = 1'b0;
    #1;
    chk("abort_write", AVM_WRITE, 1'b0);
    chk("abort_cs", AVM_CS, 1'b0);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_addr", AVM_ADDR, 0);
    chk("abort_col", CURSOR_COL, 0);
    chk("abort_row", CURSOR_ROW, 0);
    chk("abort_words", done_cnt - base, 450);
    chk("word300_hold", hold_at[300], 3);
    chk("abort_left", exp_q.size(), 150);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mcol = 0;
    mrow = 0;
    inv_m = 1'b0;
    base = done_cnt;
    repeat (30) @(negedge clk);
    chk("no_resume", done_cnt - base, 0);
    chk("ready_after_abort", CHAR_READY, 1'b1);

`ifdef VGA_CONSOLE_INVERSE_EN
    step(8'h0E, 0);
    step(8'h42, 0);
    chk("inv_data", AVM_WRITEDATA, 32'hC2C2C2C2);
    step(8'h0F, 0);
    step(8'h42, 0);
    chk("norm_data", AVM_WRITEDATA, 32'h42424242);
`else
    step(8'h0E, 0);
    chk("so_glyph_data", AVM_WRITEDATA, 32'h0E0E0E0E);
    step(8'h0F, 0);
    chk("si_glyph_data", AVM_WRITEDATA, 32'h0F0F0F0F);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
